// File: rtl/full_handshake_tx.sv
`timescale 1ns/1ps
// Transmit end of a four-phase req/ack clock-domain-crossing handshake.
// A one-word pending register lets local logic queue the next word while one is in flight.
module full_handshake_tx #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          send_valid_i,
  input  logic [DW-1:0] send_data_i,
  output logic          send_rdy_o,
  output logic          done_o,
  output logic          busy_o,
  input  logic          ack_i,
  output logic          req_o,
  output logic [DW-1:0] req_data_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    DEASSERT = 2'd2
  } state_t;

  state_t        state;
  logic          ack_meta;
  logic          ack_s;
  logic [1:0]    sync_warm;
  logic          pend_valid;
  logic [DW-1:0] pend_data;
  logic          launch_ok;
  logic          accept;

  // ack_i arrives from an unrelated clock domain: two-flop synchronizer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta  <= 1'b0;
      ack_s     <= 1'b0;
      sync_warm <= 2'b00;
    end else begin
      ack_meta  <= ack_i;
      ack_s     <= ack_meta;
      sync_warm <= {sync_warm[0], 1'b1};
    end
  end

  // After reset ack_s reads 0 until the synchronizer refills, so a stuck-high ack
  // must be seen through the flops before any launch is allowed.
  assign launch_ok  = !ack_s && sync_warm[1];
  assign accept     = send_valid_i && !pend_valid;
  assign send_rdy_o = !pend_valid;
  assign busy_o     = (state != IDLE) || pend_valid;

  // Handshake FSM with pending-word capture and launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_o      <= 1'b0;
      req_data_o <= '0;
      done_o     <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_ok && pend_valid) begin
            req_data_o <= pend_data;
            req_o      <= 1'b1;
            pend_valid <= 1'b0;
            state      <= ASSERT;
          end else if (launch_ok && accept) begin
            req_data_o <= send_data_i;
            req_o      <= 1'b1;
            state      <= ASSERT;
          end else if (accept) begin
            pend_data  <= send_data_i;
            pend_valid <= 1'b1;
          end
        end
        ASSERT: begin
          if (accept) begin
            pend_data  <= send_data_i;
            pend_valid <= 1'b1;
          end
          if (ack_s) begin
            req_o <= 1'b0;
            state <= DEASSERT;
          end
        end
        DEASSERT: begin
          if (accept) begin
            pend_data  <= send_data_i;
            pend_valid <= 1'b1;
          end
          if (!ack_s) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          req_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_full_handshake_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for full_handshake_tx: accepted words are queued in order and
// must appear on req_data_o exactly once, in order, with a legal four-phase sequence.
module tb_full_handshake_tx;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rx_clk = 1'b0;
  logic          rst_n;
  logic          send_valid;
  logic [DW-1:0] send_data;
  logic          send_rdy_o;
  logic          done_o;
  logic          busy_o;
  logic          ack_i;
  logic          req_o;
  logic [DW-1:0] req_data_o;

  logic          ack_auto;
  logic          ack_man;
  bit            rx_auto;
  real           rx_half = 5.0;

  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            launch_cnt = 0;
  logic [31:0]   exp_q[$];

  logic          mon_prev_req = 1'b0;
  logic          mon_prev_ack = 1'b0;
  bit            mon_inflight = 1'b0;
  bit            mon_changed = 1'b0;
  logic [31:0]   mon_held = '0;
  logic [31:0]   mon_exp = '0;

  assign ack_i = rx_auto ? ack_auto : ack_man;

  full_handshake_tx #(.DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .send_valid_i (send_valid),
    .send_data_i  (send_data),
    .send_rdy_o   (send_rdy_o),
    .done_o       (done_o),
    .busy_o       (busy_o),
    .ack_i        (ack_i),
    .req_o        (req_o),
    .req_data_o   (req_data_o)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #3;
    forever #(rx_half) rx_clk = ~rx_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver in its own clock domain: ack follows req after a random number of RX cycles
  initial begin : rx_model
    ack_auto = 1'b0;
    forever begin
      @(posedge rx_clk);
      if (rx_auto && (req_o !== ack_auto)) begin
        repeat ($urandom_range(0, 10)) @(posedge rx_clk);
        ack_auto = req_o;
      end
    end
  end

  // Monitor: pops the expected word at every req rise and watches protocol order and data stability
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_prev_req = 1'b0;
        mon_prev_ack = ack_i;
        mon_inflight = 1'b0;
        mon_changed  = 1'b0;
      end else begin
        if (mon_inflight && (req_data_o !== mon_held)) mon_changed = 1'b1;
        if (done_o) begin
          done_cnt++;
          chk("done_after_transfer", 64'(mon_inflight), 64'(1));
          chk("data_stable_in_flight", 64'(mon_changed), 64'(0));
          mon_inflight = 1'b0;
          mon_changed  = 1'b0;
        end
        if (req_o && !mon_prev_req) begin
          launch_cnt++;
          if (rx_auto) chk("req_rise_with_ack_low", 64'(mon_prev_ack), 64'(0));
          chk("launch_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            chk("launch_data", 64'(req_data_o), 64'(mon_exp));
          end
          mon_held     = req_data_o;
          mon_inflight = 1'b1;
          mon_changed  = 1'b0;
        end
        if (!req_o && mon_prev_req && rx_auto)
          chk("req_fall_with_ack_high", 64'(mon_prev_ack), 64'(1));
        mon_prev_req = req_o;
        mon_prev_ack = ack_i;
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; holds valid until the word is taken
  task automatic send_word(input logic [31:0] w, output int waits, output logic [31:0] rd);
    bit ok;
    ok = 1'b0;
    waits = 0;
    rd = '0;
    send_valid = 1'b1;
    send_data  = w;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (send_rdy_o === 1'b1) begin
        ok = 1'b1;
        rd = req_data_o;
        exp_q.push_back(w);
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    send_valid = 1'b0;
    send_data  = $urandom();
    chk("send_accepted", 64'(ok), 64'(1));
  endtask

  task automatic wait_idle(input int budget);
    int i;
    i = 0;
    while ((busy_o !== 1'b0 || ack_i !== 1'b0) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("idle_reached", 64'(i < budget), 64'(1));
  endtask

  task automatic run_random(input int n, input real half, input string tag);
    int d0, l0, waits;
    logic [31:0] rd;
    rx_half = half;
    rx_auto = 1'b1;
    d0 = done_cnt;
    l0 = launch_cnt;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
      send_word($urandom(), waits, rd);
    end
    wait_idle(20000);
    chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'(n));
    chk({tag, "_launch_count"}, 64'(launch_cnt - l0), 64'(n));
    chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
  endtask

  int          waits1, waits2, waits3, d0, l0, highs;
  logic [31:0] rd1, rd2, rd3;
  bit          found;

  initial begin : main
    rst_n      = 1'b0;
    send_valid = 1'b0;
    send_data  = '0;
    ack_man    = 1'b0;
    rx_auto    = 1'b0;
    #12;
    chk("reset_req_o", 64'(req_o), 64'(0));
    chk("reset_req_data_o", 64'(req_data_o), 64'(0));
    chk("reset_done_o", 64'(done_o), 64'(0));
    chk("reset_busy_o", 64'(busy_o), 64'(0));
    chk("reset_send_rdy_o", 64'(send_rdy_o), 64'(1));
    #5 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Single word with manually driven ack
    send_word(32'hA5A5_0001, waits1, rd1);
    @(negedge clk);
    chk("single_req_rise", 64'(req_o), 64'(1));
    chk("single_req_data", 64'(req_data_o), 64'(32'hA5A5_0001));
    repeat (3) @(posedge clk);
    #1 ack_man = 1'b1;
    repeat (3) @(negedge clk);
    chk("single_req_held", 64'(req_o), 64'(1));
    @(negedge clk);
    chk("single_req_fall", 64'(req_o), 64'(0));
    ack_man = 1'b0;
    repeat (2) @(negedge clk);
    chk("single_done_early", 64'(done_o), 64'(0));
    @(negedge clk);
    chk("single_done_pulse", 64'(done_o), 64'(1));
    @(negedge clk);
    chk("single_done_one_cycle", 64'(done_o), 64'(0));
    wait_idle(100);
    chk("single_queue_empty", 64'(exp_q.size()), 64'(0));

    // Back-to-back words 1, 2, 3
    rx_auto = 1'b1;
    d0 = done_cnt;
    align();
    send_word(32'd1, waits1, rd1);
    send_word(32'd2, waits2, rd2);
    send_word(32'd3, waits3, rd3);
    chk("b2b_w2_no_wait", 64'(waits2), 64'(0));
    chk("b2b_w3_stalled", 64'(waits3 > 0), 64'(1));
    chk("b2b_w3_taken_after_w2_launch", 64'(rd3), 64'(2));
    wait_idle(2000);
    chk("b2b_done_count", 64'(done_cnt - d0), 64'(3));

    align();
    run_random(1000, 5.0, "rand_1x");
    align();
    run_random(200, 13.514, "ratio_0p37");
    align();
    run_random(300, 1.724, "ratio_2p9");

    // Stuck-high ack across a TX-only reset
    align();
    rx_auto = 1'b0;
    ack_man = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    send_word(32'hDEAD_BEEF, waits1, rd1);
    highs = 0;
    repeat (6) begin
      @(negedge clk);
      if (req_o) highs++;
    end
    chk("stuck_req_low", 64'(highs), 64'(0));
    chk("stuck_busy", 64'(busy_o), 64'(1));
    chk("stuck_rdy_low", 64'(send_rdy_o), 64'(0));
    ack_man = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      @(negedge clk);
      if (req_o) found = 1'b1;
    end
    chk("stuck_release_launch", 64'(found), 64'(1));
    rx_auto = 1'b1;
    wait_idle(500);
    chk("stuck_done_count", 64'(done_cnt - d0), 64'(1));
    chk("stuck_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset while in ASSERT with a word pending
    align();
    rx_auto = 1'b0;
    ack_man = 1'b0;
    send_word(32'h1111_0001, waits1, rd1);
    send_word(32'h1111_0002, waits2, rd2);
    d0 = done_cnt;
    l0 = launch_cnt;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req_o", 64'(req_o), 64'(0));
    chk("midrst_busy_o", 64'(busy_o), 64'(0));
    chk("midrst_send_rdy_o", 64'(send_rdy_o), 64'(1));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'(0));
    chk("midrst_pending_lost", 64'(launch_cnt - l0), 64'(0));
    chk("midrst_req_idle", 64'(req_o), 64'(0));

    // Recovery after reset
    rx_auto = 1'b1;
    d0 = done_cnt;
    align();
    send_word(32'h5A5A_C0DE, waits1, rd1);
    wait_idle(500);
    chk("recover_done_count", 64'(done_cnt - d0), 64'(1));
    chk("recover_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
